// File: rtl/frequency_selector.sv
// ---------------------------------------------------------------------------
// frequency_selector
//
// Operator-input stage in front of display_control. Three active-low push
// buttons set a reference frequency and a display scale:
//   - btn_up_n / btn_down_n step the frequency by the amount chosen on
//     step_sel. Holding a button starts auto-repeat after a delay.
//   - btn_scale_n cycles the display scale 00 -> 01 -> 10 -> 11 -> 00.
// Every button is synchronised (2 FF), debounced and edge-detected before use.
//
// Build option:
//   SELECTOR_WRAP_EN  defined   : out-of-range results wrap
//                                 (above max -> 1, below 1 -> max).
//                     undefined : out-of-range results saturate at 1 / max.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   reset          synchronous, active-high reset
//   btn_up_n       increment button, active-low, asynchronous
//   btn_down_n     decrement button, active-low, asynchronous
//   btn_scale_n    scale-cycle button, active-low, asynchronous
//   step_sel[1:0]  step size: 00=1, 01=10, 10=100, 11=1000
//   frequency_out  selected frequency (1..FREQUENCY_RANGE-1), registered
//   scale_out      selected display scale, registered
//   update_pulse   one-cycle strobe in the first cycle a changed output value
//                  is visible
// ---------------------------------------------------------------------------
module frequency_selector #(
    // The output is 13 bits wide, so FREQUENCY_RANGE must not exceed 8192.
    parameter int unsigned FREQUENCY_RANGE     = 8192,
    parameter int unsigned DEFAULT_FREQUENCY   = 1000,
    parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up_n,
    input  logic        btn_down_n,
    input  logic        btn_scale_n,
    input  logic [1:0]  step_sel,
    output logic [12:0] frequency_out,
    output logic [1:0]  scale_out,
    output logic        update_pulse
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int unsigned DB_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned TM_MAX =
        (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES
                                                   : REPEAT_RATE_CYCLES;
    localparam int unsigned TM_W = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;
    localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE_CYCLES - 1);

    // 14-bit so that the comparison against the sum cannot overflow.
    localparam logic [13:0] FREQ_MAX    = 14'(FREQUENCY_RANGE - 1);
    localparam logic [12:0] FREQ_MAX_13 = 13'(FREQUENCY_RANGE - 1);
    localparam logic [12:0] FREQ_MIN_13 = 13'd1;
    localparam logic [12:0] FREQ_RESET  = 13'(DEFAULT_FREQUENCY);

    // Button indices into the per-button vectors.
    localparam int unsigned BtnUp    = 0;
    localparam int unsigned BtnDown  = 1;
    localparam int unsigned BtnScale = 2;

    // Up/down FSM states.
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHold   = 2'd1;
    localparam logic [1:0] StRepeat = 2'd2;

    // -----------------------------------------------------------------------
    // Synchronise, debounce and edge-detect the three buttons
    // -----------------------------------------------------------------------
    // Levels are kept raw (1 = released) all the way to the stable state.
    logic [2:0]            btn_raw;
    logic [2:0]            sync1_q;
    logic [2:0]            sync2_q;
    logic [2:0]            stable_q;
    logic [2:0]            press_q;
    logic [2:0][DB_W-1:0]  db_cnt_q;

    assign btn_raw = {btn_scale_n, btn_down_n, btn_up_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 3'b111;
            sync2_q  <= 3'b111;
            stable_q <= 3'b111;
            press_q  <= 3'b000;
            db_cnt_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    stable_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                    // Only released -> pressed produces a press event.
                    press_q[i]  <= ~sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    logic press_up;
    logic press_down;
    logic press_scale;

    assign press_up    = press_q[BtnUp];
    assign press_down  = press_q[BtnDown];
    assign press_scale = press_q[BtnScale];

    // -----------------------------------------------------------------------
    // Step decode and saturating / wrapping arithmetic
    // -----------------------------------------------------------------------
    logic [12:0] freq_q;
    logic [12:0] freq_d;
    logic [1:0]  scale_q;
    logic [1:0]  scale_d;
    logic        pulse_q;
    logic        pulse_d;

    logic [12:0] step;
    logic [13:0] sum;
    logic [13:0] diff;
    logic [12:0] inc_val;
    logic [12:0] dec_val;

    // step_sel is decoded live so the value applied is whatever is selected
    // at the moment the step happens.
    always_comb begin
        step = 13'd1;
        unique case (step_sel)
            2'b00: step = 13'd1;
            2'b01: step = 13'd10;
            2'b10: step = 13'd100;
            2'b11: step = 13'd1000;
        endcase
    end

    always_comb begin
        sum     = {1'b0, freq_q} + {1'b0, step};
        diff    = {1'b0, freq_q} - {1'b0, step};
        inc_val = sum[12:0];
        dec_val = diff[12:0];
`ifdef SELECTOR_WRAP_EN
        if (sum > FREQ_MAX) begin
            inc_val = FREQ_MIN_13;
        end
        // diff[13] is the borrow: freq_q < step.
        if (diff[13] || (diff == 14'd0)) begin
            dec_val = FREQ_MAX_13;
        end
`else
        if (sum > FREQ_MAX) begin
            inc_val = FREQ_MAX_13;
        end
        if (diff[13] || (diff == 14'd0)) begin
            dec_val = FREQ_MIN_13;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Up/down FSM with hold-to-auto-repeat
    // -----------------------------------------------------------------------
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [TM_W-1:0] timer_q;
    logic [TM_W-1:0] timer_d;
    logic            dir_q;      // 0 = up, 1 = down
    logic            dir_d;
    logic            apply_step;
    logic            step_down;
    logic            dir_released;

    assign dir_released = dir_q ? stable_q[BtnDown] : stable_q[BtnUp];

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dir_d      = dir_q;
        apply_step = 1'b0;
        step_down  = dir_q;

        unique case (state_q)
            StIdle: begin
                timer_d   = '0;
                step_down = press_down;
                // Simultaneous up and down presses cancel out.
                if (press_up ^ press_down) begin
                    apply_step = 1'b1;
                    dir_d      = press_down;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (dir_released) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else if (timer_q == DELAY_LAST) begin
                    apply_step = 1'b1;
                    timer_d    = '0;
                    state_d    = StRepeat;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            StRepeat: begin
                if (dir_released) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else if (timer_q == RATE_LAST) begin
                    apply_step = 1'b1;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + TM_W'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output next-state
    // -----------------------------------------------------------------------
    always_comb begin
        freq_d = freq_q;
        if (apply_step) begin
            freq_d = step_down ? dec_val : inc_val;
        end
        scale_d = press_scale ? (scale_q + 2'd1) : scale_q;
        // A saturated step leaves freq_d unchanged and so raises no pulse.
        pulse_d = (freq_d != freq_q) || (scale_d != scale_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            dir_q   <= 1'b0;
            freq_q  <= FREQ_RESET;
            scale_q <= 2'b00;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            freq_q  <= freq_d;
            scale_q <= scale_d;
            pulse_q <= pulse_d;
        end
    end

    assign frequency_out = freq_q;
    assign scale_out     = scale_q;
    assign update_pulse  = pulse_q;

endmodule

// File: tb/tb_frequency_selector.sv
module tb_frequency_selector;

    localparam int FR  = 8192;
    localparam int DEF = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_up_n;
    logic        btn_down_n;
    logic        btn_scale_n;
    logic [1:0]  step_sel;
    logic [12:0] frequency_out;
    logic [1:0]  scale_out;
    logic        update_pulse;

    always #5 clk = ~clk;

    frequency_selector #(
        .FREQUENCY_RANGE     (FR),
        .DEFAULT_FREQUENCY   (DEF),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_up_n      (btn_up_n),
        .btn_down_n    (btn_down_n),
        .btn_scale_n   (btn_scale_n),
        .step_sel      (step_sel),
        .frequency_out (frequency_out),
        .scale_out     (scale_out),
        .update_pulse  (update_pulse)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          exp_freq;
    int          exp_scale;
    int          pulses;
    logic [12:0] prev_freq;
    logic [1:0]  prev_scale;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the frequency rules.
    function automatic int step_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 10;
            2'b10:   return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic int model_up(input int f, input int s);
        int r = f + s;
        if (r > FR - 1) begin
`ifdef SELECTOR_WRAP_EN
            r = 1;
`else
            r = FR - 1;
`endif
        end
        return r;
    endfunction

    function automatic int model_down(input int f, input int s);
        int r = f - s;
        if (r < 1) begin
`ifdef SELECTOR_WRAP_EN
            r = FR - 1;
`else
            r = 1;
`endif
        end
        return r;
    endfunction

    // Advance n cycles, sampling on the falling edge. Outside reset, a pulse
    // must appear exactly in the cycles where an output differs from before.
    task automatic tick(input int n);
        logic changed;
        repeat (n) begin
            @(negedge clk);
            changed = (frequency_out !== prev_freq) || (scale_out !== prev_scale);
            if (!reset) begin
                check("pulse_vs_change", 32'(update_pulse), 32'(changed));
            end
            pulses    += int'(update_pulse);
            prev_freq  = frequency_out;
            prev_scale = scale_out;
        end
    endtask

    // Short press (no auto-repeat) of any button combination, then compare
    // outputs and pulse count against the model.
    task automatic press_and_check(input bit up, input bit down, input bit scl,
                                   input int hold, input string tag);
        int old_f = exp_freq;
        int old_s = exp_scale;
        int exp_p;
        if (up && !down) exp_freq = model_up(exp_freq, step_of(step_sel));
        if (down && !up) exp_freq = model_down(exp_freq, step_of(step_sel));
        if (scl) exp_scale = (exp_scale + 1) % 4;
        exp_p = ((exp_freq != old_f) || (exp_scale != old_s)) ? 1 : 0;
        pulses      = 0;
        btn_up_n    = !up;
        btn_down_n  = !down;
        btn_scale_n = !scl;
        tick(hold);
        btn_up_n    = 1'b1;
        btn_down_n  = 1'b1;
        btn_scale_n = 1'b1;
        tick(14);
        check({tag, "_freq"}, 32'(frequency_out), 32'(exp_freq));
        check({tag, "_scale"}, 32'(scale_out), 32'(exp_scale));
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_p));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset     = 1'b0;
        exp_freq  = DEF;
        exp_scale = 0;
    endtask

    initial begin
        int f;
        int exp_p;
        int kind;

        reset       = 1'b1;
        btn_up_n    = 1'b1;
        btn_down_n  = 1'b1;
        btn_scale_n = 1'b1;
        step_sel    = 2'b00;
        prev_freq   = 13'(DEF);
        prev_scale  = 2'b00;
        pulses      = 0;

        // Reset held for five cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_freq", 32'(frequency_out), 32'(DEF));
            check("reset_scale", 32'(scale_out), 32'd0);
            check("reset_pulse", 32'(update_pulse), 32'd0);
        end
        reset     = 1'b0;
        exp_freq  = DEF;
        exp_scale = 0;
        tick(3);

        // Single step of 100.
        step_sel = 2'b10;
        press_and_check(1'b1, 1'b0, 1'b0, 10, "up100");
        check("up100_value", 32'(frequency_out), 32'd1100);

        // Bounce shorter than the debounce window is rejected.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            btn_up_n = 1'b0;
            tick(2);
            btn_up_n = 1'b1;
            tick(2);
        end
        tick(12);
        check("bounce_freq", 32'(frequency_out), 32'(exp_freq));
        check("bounce_pulses", 32'(pulses), 32'd0);

        // Long down hold: initial step, delayed step, then repeats
        // (six applied steps in a 60-cycle hold).
        step_sel   = 2'b11;
        pulses     = 0;
        btn_down_n = 1'b0;
        tick(10);
        check("hold_first", 32'(frequency_out), 32'(model_down(exp_freq, 1000)));
        tick(20);
        check("hold_delayed", 32'(frequency_out),
              32'(model_down(model_down(exp_freq, 1000), 1000)));
        tick(30);
        btn_down_n = 1'b1;
        tick(14);
        exp_p = 0;
        for (int i = 0; i < 6; i++) begin
            f = model_down(exp_freq, 1000);
            if (f != exp_freq) exp_p++;
            exp_freq = f;
        end
        check("hold_final", 32'(frequency_out), 32'(exp_freq));
        check("hold_pulses", 32'(pulses), 32'(exp_p));

        // Reset in the middle of a hold; the still-held button is re-accepted.
        step_sel = 2'b01;
        btn_up_n = 1'b0;
        tick(10);
        do_reset(3);
        check("midreset_freq", 32'(frequency_out), 32'(DEF));
        pulses = 0;
        tick(12);
        btn_up_n = 1'b1;
        tick(14);
        exp_freq = model_up(DEF, 10);
        check("midreset_after", 32'(frequency_out), 32'(exp_freq));
        check("midreset_pulses", 32'(pulses), 32'd1);

        // Climb to 8000, then hit the upper bound twice.
        do_reset(3);
        step_sel = 2'b11;
        for (int i = 0; i < 7; i++) press_and_check(1'b1, 1'b0, 1'b0, 8, "climb");
        check("at_8000", 32'(frequency_out), 32'd8000);
        press_and_check(1'b1, 1'b0, 1'b0, 8, "top1");
        check("top1_value", 32'(frequency_out), 32'd8191);
        press_and_check(1'b1, 1'b0, 1'b0, 8, "top2");

        // Five scale presses, then scale coincident with a frequency step.
        for (int i = 0; i < 5; i++) press_and_check(1'b0, 1'b0, 1'b1, 8, "scale");
        check("scale_after5", 32'(scale_out), 32'd1);
        press_and_check(1'b0, 1'b1, 1'b0, 8, "down_before_combo");
        step_sel = 2'b00;
        press_and_check(1'b1, 1'b0, 1'b1, 8, "combo");

        // Randomised presses, biased towards the big step to reach the bounds.
        for (int i = 0; i < 30; i++) begin
            step_sel = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 6));
            case (kind)
                0:       press_and_check(1'b1, 1'b0, 1'b0, int'($urandom_range(6, 12)), "rnd_up");
                1:       press_and_check(1'b0, 1'b1, 1'b0, int'($urandom_range(6, 12)), "rnd_down");
                2:       press_and_check(1'b0, 1'b0, 1'b1, int'($urandom_range(6, 12)), "rnd_scale");
                3:       press_and_check(1'b1, 1'b0, 1'b1, int'($urandom_range(6, 12)), "rnd_up_sc");
                4:       press_and_check(1'b0, 1'b1, 1'b1, int'($urandom_range(6, 12)), "rnd_dn_sc");
                5:       press_and_check(1'b1, 1'b1, 1'b0, int'($urandom_range(6, 12)), "rnd_both");
                default: press_and_check(1'b1, 1'b1, 1'b1, int'($urandom_range(6, 12)), "rnd_all");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
